game_timer: RTL and testbench

//  Stopwatch that produces the game_time bus read by the end-of-game popup and the HUD.

---
 rtl/game_timer.sv | 128 ++++++++++++
 tb/tb_game_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/game_timer.sv
`timescale 1ns/1ps
// game_timer
//   Play-time stopwatch. Counts elapsed time in hundredths of a second from
//   pclk and publishes it as a static bus for the HUD and end-of-game popup.
//
// Parameters
//   CLK_FREQ_HZ  pclk frequency; must be a multiple of 100 and >= 200
//   SEC_MAX      highest seconds value shown (fits 6 bits)
//
// Ports
//   pclk        in   pixel clock, the only clock
//   rst         in   asynchronous active-low reset
//   start       in   1-cycle pulse: clear the time and start counting
//   stop        in   1-cycle pulse: freeze the time
//   pause       in   level: hold prescaler and time while running
//   game_time   out  {seconds[12:7], hundredths[6:0]}
//   running     out  high while counting is enabled
//   saturated   out  high once the time has reached SEC_MAX.99
//   tick_100hz  out  1-cycle strobe on every hundredths increment
module game_timer #(
  parameter int unsigned CLK_FREQ_HZ = 65_000_000,
  parameter int unsigned SEC_MAX     = 63
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  output logic [12:0] game_time,
  output logic        running,
  output logic        saturated,
  output logic        tick_100hz
);

  localparam int unsigned   TICK_DIV   = CLK_FREQ_HZ / 100;
  localparam int unsigned   PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    SEC_LAST   = 6'(SEC_MAX);

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    STOPPED
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] presc, presc_next;
  logic [5:0]    sec, sec_next;
  logic [6:0]    hund, hund_next;
  logic          sat_next;
  logic          tick_next;
  logic          running_next;
  logic          presc_wrap;
  logic          inc;

  assign presc_wrap = (state == RUNNING) && !pause && (presc == PRESC_LAST);
  assign inc        = presc_wrap && !saturated;

  // State and output registers
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      presc      <= '0;
      sec        <= '0;
      hund       <= '0;
      saturated  <= 1'b0;
      tick_100hz <= 1'b0;
      running    <= 1'b0;
    end else begin
      state      <= state_next;
      presc      <= presc_next;
      sec        <= sec_next;
      hund       <= hund_next;
      saturated  <= sat_next;
      tick_100hz <= tick_next;
      running    <= running_next;
    end
  end

  // Next-state logic: start overrides everything, including a same-cycle stop
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RUNNING;
    end else begin
      unique case (state)
        RUNNING: if (stop) state_next = STOPPED;
        default: state_next = state;
      endcase
    end
  end

  // Datapath / output next values. An increment on the same edge as stop is
  // still applied because this block only looks at the current state.
  always_comb begin
    presc_next   = presc;
    sec_next     = sec;
    hund_next    = hund;
    sat_next     = saturated;
    tick_next    = 1'b0;
    running_next = (state_next == RUNNING);

    if (start) begin
      presc_next = '0;
      sec_next   = '0;
      hund_next  = '0;
      sat_next   = 1'b0;
    end else if ((state == RUNNING) && !pause) begin
      presc_next = presc_wrap ? '0 : presc + 1'b1;
      if (inc) begin
        tick_next = 1'b1;
        if (hund == 7'd99) begin
          hund_next = '0;
          sec_next  = sec + 6'd1;
        end else begin
          hund_next = hund + 7'd1;
        end
        // Landing on SEC_MAX.99 freezes the time from this edge onward
        if ((sec == SEC_LAST) && (hund == 7'd98)) begin
          sat_next = 1'b1;
        end
      end
    end
  end

  assign game_time = {sec, hund};

endmodule

// File: tb/tb_game_timer.sv
`timescale 1ns/1ps
module tb_game_timer;

  logic        pclk;
  logic        rst;
  logic        start;
  logic        stop;
  logic        pause;
  logic [12:0] game_time;
  logic        running;
  logic        saturated;
  logic        tick_100hz;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  game_timer #(
    .CLK_FREQ_HZ(1000),
    .SEC_MAX    (63)
  ) dut (
    .pclk      (pclk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .game_time (game_time),
    .running   (running),
    .saturated (saturated),
    .tick_100hz(tick_100hz)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        start;
    logic        stop;
    logic        pause;
    int unsigned cycles;
    logic [12:0] t;
    logic        run;
    logic        sat;
    logic        tick;
  } vec_t;

  localparam int NV = 16;
  vec_t vec[NV];

  task automatic check_t(input string name, input logic [12:0] act, input logic [12:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 13'h%03h, expected 13'h%03h", name, act, exp);
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    int unsigned ticks;

    rst   = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;

    // Vectors run back to back from IDLE; start edge is E0, first tick at E10
    //              start stop  pause cyc   time     run   sat   tick
    vec[0]  = '{1'b0, 1'b1, 1'b0, 20,   13'h000, 1'b0, 1'b0, 1'b0}; // stop in IDLE
    vec[1]  = '{1'b1, 1'b0, 1'b0, 10,   13'h000, 1'b1, 1'b0, 1'b0}; // E0..E9
    vec[2]  = '{1'b0, 1'b0, 1'b0, 1,    13'h001, 1'b1, 1'b0, 1'b1}; // E10 first tick
    vec[3]  = '{1'b0, 1'b0, 1'b0, 1,    13'h001, 1'b1, 1'b0, 1'b0}; // strobe is 1 cycle
    vec[4]  = '{1'b0, 1'b0, 1'b0, 989,  13'h080, 1'b1, 1'b0, 1'b1}; // E1000: 1.00 s wrap
    vec[5]  = '{1'b0, 1'b0, 1'b0, 5,    13'h080, 1'b1, 1'b0, 1'b0}; // prescaler at 5
    vec[6]  = '{1'b0, 1'b0, 1'b1, 47,   13'h080, 1'b1, 1'b0, 1'b0}; // paused 47
    vec[7]  = '{1'b0, 1'b0, 1'b0, 4,    13'h080, 1'b1, 1'b0, 1'b0}; // phase kept: at 9
    vec[8]  = '{1'b0, 1'b0, 1'b0, 1,    13'h081, 1'b1, 1'b0, 1'b1}; // delayed tick
    vec[9]  = '{1'b0, 1'b0, 1'b0, 1039, 13'h104, 1'b1, 1'b0, 1'b0}; // prescaler at 9
    vec[10] = '{1'b0, 1'b1, 1'b0, 1,    13'h105, 1'b0, 1'b0, 1'b1}; // stop + increment
    vec[11] = '{1'b0, 1'b0, 1'b0, 500,  13'h105, 1'b0, 1'b0, 1'b0}; // held
    vec[12] = '{1'b0, 1'b1, 1'b0, 20,   13'h105, 1'b0, 1'b0, 1'b0}; // second stop
    vec[13] = '{1'b1, 1'b1, 1'b0, 1,    13'h000, 1'b1, 1'b0, 1'b0}; // start wins
    vec[14] = '{1'b0, 1'b0, 1'b0, 9,    13'h000, 1'b1, 1'b0, 1'b0};
    vec[15] = '{1'b0, 1'b0, 1'b0, 1,    13'h001, 1'b1, 1'b0, 1'b1}; // restart counts

    // Reset values, before any clock edge
    #2;
    check_t("reset time", game_time, 13'h000);
    check_b("reset running", running, 1'b0);
    check_b("reset saturated", saturated, 1'b0);
    check_b("reset tick", tick_100hz, 1'b0);
    #10 rst = 1'b1;
    step(1);

    for (int i = 0; i < NV; i++) begin
      start = vec[i].start;
      stop  = vec[i].stop;
      pause = vec[i].pause;
      step(1);
      start = 1'b0;
      stop  = 1'b0;
      if (vec[i].cycles > 1) step(vec[i].cycles - 1);
      check_t($sformatf("v%0d time", i), game_time, vec[i].t);
      check_b($sformatf("v%0d running", i), running, vec[i].run);
      check_b($sformatf("v%0d saturated", i), saturated, vec[i].sat);
      check_b($sformatf("v%0d tick", i), tick_100hz, vec[i].tick);
    end
    pause = 1'b0;

    // Asynchronous reset mid-cycle, right after the 1.05 s tick
    step(1040);
    check_t("pre-reset time", game_time, 13'h085);
    check_b("pre-reset tick", tick_100hz, 1'b1);
    #3 rst = 1'b0;
    #1;
    check_t("async reset time", game_time, 13'h000);
    check_b("async reset running", running, 1'b0);
    check_b("async reset tick", tick_100hz, 1'b0);
    @(posedge pclk);
    #3 rst = 1'b1;
    step(30);
    check_t("post-reset idle time", game_time, 13'h000);
    check_b("post-reset idle running", running, 1'b0);

    // Saturation at 63.99 s (tick 6399 lands on E63990)
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(63989);
    check_t("pre-sat time", game_time, 13'h1FE2);
    check_b("pre-sat saturated", saturated, 1'b0);
    step(1);
    check_t("sat time", game_time, 13'h1FE3);
    check_b("sat saturated", saturated, 1'b1);
    check_b("sat tick", tick_100hz, 1'b1);
    check_b("sat running", running, 1'b1);
    ticks = 0;
    for (int i = 0; i < 200; i++) begin
      step(1);
      if (tick_100hz) ticks++;
    end
    check_b("sat no more ticks", (ticks == 0), 1'b1);
    check_t("sat hold time", game_time, 13'h1FE3);
    check_b("sat hold running", running, 1'b1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    check_b("sat stop running", running, 1'b0);
    check_t("sat stop time", game_time, 13'h1FE3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    check_b("restart clears saturated", saturated, 1'b0);
    check_t("restart time", game_time, 13'h000);
    check_b("restart running", running, 1'b1);
    step(10);
    check_t("restart first tick", game_time, 13'h001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
